// File: rtl/axi_ar_burst_splitter.sv
// axi_ar_burst_splitter
// Splits one upstream AXI INCR read burst (full-width beats) into downstream
// sub-bursts of at most MAX_SUB_BEATS beats. A small FIFO holds one "final"
// flag per outstanding sub-burst. The R channel passes straight through, and
// only the last beat of the final sub-burst keeps its last flag.
//
// Reset is asynchronous and active-high, on the port named rst_n.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A source holds its payload stable while valid is high and ready is low.
//
// Optional feature: define AR_SPLIT_STATS_EN to build the statistics
// counters. Without it, stat_in_cnt and stat_sub_cnt are tied to zero.
module axi_ar_burst_splitter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 512,
    parameter int ID_WIDTH      = 5,
    parameter int MAX_SUB_BEATS = 16,
    parameter int PEND_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // upstream AR
    input  logic                  slv_ar_valid,
    output logic                  slv_ar_ready,
    input  logic [ADDR_WIDTH-1:0] slv_ar_addr,
    input  logic [7:0]            slv_ar_len,
    input  logic [ID_WIDTH-1:0]   slv_ar_id,
    // downstream AR
    output logic                  mst_ar_valid,
    input  logic                  mst_ar_ready,
    output logic [ADDR_WIDTH-1:0] mst_ar_addr,
    output logic [7:0]            mst_ar_len,
    output logic [ID_WIDTH-1:0]   mst_ar_id,
    // downstream R
    input  logic                  mst_r_valid,
    output logic                  mst_r_ready,
    input  logic [DATA_WIDTH-1:0] mst_r_data,
    input  logic [ID_WIDTH-1:0]   mst_r_id,
    input  logic [1:0]            mst_r_resp,
    input  logic                  mst_r_last,
    // upstream R
    output logic                  slv_r_valid,
    input  logic                  slv_r_ready,
    output logic [DATA_WIDTH-1:0] slv_r_data,
    output logic [ID_WIDTH-1:0]   slv_r_id,
    output logic [1:0]            slv_r_resp,
    output logic                  slv_r_last,
    // statistics
    output logic [31:0]           stat_in_cnt,
    output logic [31:0]           stat_sub_cnt,
    // FSM state for debug: 0 = IDLE, 1 = SPLIT
    output logic                  dbg_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PW    = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int CW    = $clog2(PEND_DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t                  state;
    logic                    ar_ready_q;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [8:0]              remaining;
    logic [ID_WIDTH-1:0]     id;

    logic [PEND_DEPTH-1:0]   final_flags;
    logic [PW-1:0]           wr_idx;
    logic [PW-1:0]           rd_idx;
    logic [CW-1:0]           count;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    is_final;
    logic [8:0]              sub_beats;
    logic                    slv_ar_hs;
    logic                    mst_ar_hs;
    logic                    pop;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(PEND_DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    assign fifo_full  = (count == CW'(PEND_DEPTH));
    assign fifo_empty = (count == '0);

    // The current sub-burst is the last one when what remains fits in one.
    assign is_final  = (remaining <= 9'(MAX_SUB_BEATS));
    assign sub_beats = is_final ? remaining : 9'(MAX_SUB_BEATS);

    assign slv_ar_ready = ar_ready_q;
    assign slv_ar_hs    = slv_ar_valid && ar_ready_q;

    // The payload is built only from registers that change on a handshake,
    // so it stays stable while the downstream slave stalls.
    assign mst_ar_valid = (state == SPLIT) && !fifo_full;
    assign mst_ar_addr  = addr;
    assign mst_ar_id    = id;
    assign mst_ar_len   = 8'(sub_beats - 9'd1);
    assign mst_ar_hs    = mst_ar_valid && mst_ar_ready;

    // R channel passes straight through, with no added latency.
    assign slv_r_valid = mst_r_valid;
    assign mst_r_ready = slv_r_ready;
    assign slv_r_data  = mst_r_data;
    assign slv_r_id    = mst_r_id;
    assign slv_r_resp  = mst_r_resp;
    // A beat that arrives with no pending sub-burst is passed on as not-last.
    assign slv_r_last  = mst_r_last && !fifo_empty && final_flags[rd_idx];
    assign pop         = mst_r_valid && slv_r_ready && mst_r_last && !fifo_empty;

    assign dbg_state = (state == SPLIT);

    // Burst FSM: take an upstream AR in IDLE, then issue sub-bursts in SPLIT.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            ar_ready_q <= 1'b0;
            addr       <= '0;
            remaining  <= '0;
            id         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (slv_ar_hs) begin
                        addr       <= slv_ar_addr;
                        id         <= slv_ar_id;
                        remaining  <= {1'b0, slv_ar_len} + 9'd1;
                        state      <= SPLIT;
                        ar_ready_q <= 1'b0;
                    end
                end
                SPLIT: begin
                    if (mst_ar_hs) begin
                        addr      <= addr + (ADDR_WIDTH'(sub_beats) * ADDR_WIDTH'(BYTES));
                        remaining <= remaining - sub_beats;
                        if (is_final) begin
                            state      <= IDLE;
                            ar_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    ar_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Pending-flag FIFO: push on each downstream AR, pop on each sub-burst's last R beat.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            final_flags <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            count       <= '0;
        end else begin
            if (mst_ar_hs) begin
                final_flags[wr_idx] <= is_final;
                wr_idx              <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({mst_ar_hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef AR_SPLIT_STATS_EN
    logic [31:0] in_cnt;
    logic [31:0] sub_cnt;

    assign stat_in_cnt  = in_cnt;
    assign stat_sub_cnt = sub_cnt;

    // Handshake counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            in_cnt  <= '0;
            sub_cnt <= '0;
        end else begin
            if (slv_ar_hs) in_cnt  <= in_cnt + 32'd1;
            if (mst_ar_hs) sub_cnt <= sub_cnt + 32'd1;
        end
    end
`else
    assign stat_in_cnt  = '0;
    assign stat_sub_cnt = '0;
`endif

endmodule

// File: doc/axi_ar_burst_splitter.md
AXI_AR_BURST_SPLITTER -- requirements
Module: axi_ar_burst_splitter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, AXI data width; beat size in bytes BYTES=DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 5, AXI ID width.
REQ-004 SHALL have parameter MAX_SUB_BEATS, default 16, maximum beats per downstream burst, power of two, range 1..256.
REQ-005 SHALL have parameter PEND_DEPTH, default 8, number of outstanding downstream sub-bursts, power of two.
REQ-006 SHALL have clk  input  1  clock, rising edge.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have slv_ar_valid/slv_ar_ready  input/output  1  upstream AR handshake.
REQ-009 SHALL have slv_ar_addr, slv_ar_len, slv_ar_id  input  ADDR_WIDTH/8/ID_WIDTH  upstream AR payload.
REQ-010 SHALL have mst_ar_valid/mst_ar_ready  output/input  1  downstream AR handshake, to the DRAM model.
REQ-011 SHALL have mst_ar_addr, mst_ar_len, mst_ar_id  output  ADDR_WIDTH/8/ID_WIDTH  downstream AR payload.
REQ-012 SHALL have mst_r_valid/mst_r_ready, mst_r_data, mst_r_id, mst_r_resp, mst_r_last  in/out, in, in, in, in  1/1, DATA_WIDTH, ID_WIDTH, 2, 1  downstream R channel.
REQ-013 SHALL have slv_r_valid/slv_r_ready, slv_r_data, slv_r_id, slv_r_resp, slv_r_last  out/in, out, out, out, out  same widths  upstream R channel.
REQ-014 SHALL have stat_in_cnt, stat_sub_cnt  output  32 each  statistics counters (see Configuration).

Function
REQ-015 SHALL accept only INCR bursts of full-width beats (size = log2(BYTES)); other types are out of scope and not checked.
REQ-016 SHALL implement FSM IDLE/SPLIT; slv_ar_ready=1 only in IDLE.
REQ-017 On slv AR handshake in IDLE SHALL latch addr, id, remaining=len+1 (9-bit) and enter SPLIT next cycle.
REQ-018 In SPLIT SHALL drive mst_ar_valid=1 while pending FIFO not full, with mst_ar_addr=current addr, mst_ar_id=latched id, mst_ar_len=min(remaining,MAX_SUB_BEATS)-1.
REQ-019 On mst AR handshake SHALL push final=(remaining<=MAX_SUB_BEATS) into pending FIFO, add sub-beats*BYTES to addr (wrap modulo 2^ADDR_WIDTH), subtract sub-beats from remaining; return to IDLE if final.
REQ-020 mst AR payload SHALL remain stable while mst_ar_valid=1 and mst_ar_ready=0.
REQ-021 R path SHALL be combinational pass-through: slv_r_valid=mst_r_valid, mst_r_ready=slv_r_ready, data/id/resp unchanged, zero latency.
REQ-022 slv_r_last SHALL equal mst_r_last AND FIFO head final; FIFO SHALL pop on R handshake with mst_r_last=1.
REQ-023 Push and pop in the same cycle SHALL be allowed, including when FIFO is full (occupancy unchanged; mst_ar_valid still gated by full at cycle start).
REQ-024 mst_r_valid with empty FIFO is a protocol error; SHALL pass beat with slv_r_last=0 and not pop.
REQ-025 Downstream is assumed in-order across sub-bursts of one ID; block SHALL NOT reorder.

Reset
REQ-026 While rst_n=1: FSM=IDLE, FIFO empty, addr/remaining/id=0, slv_ar_ready=0, mst_ar_valid=0, counters=0.
REQ-027 slv_ar_ready SHALL rise the first cycle after rst_n deasserts.
REQ-028 Reset mid-burst SHALL discard remaining sub-bursts and pending flags; R beats arriving after reset pass through with slv_r_last=0.

Configuration
REQ-029 Macro AR_SPLIT_STATS_EN defined: stat_in_cnt increments per slv AR handshake, stat_sub_cnt per mst AR handshake, both wrap at 2^32.
REQ-030 Macro AR_SPLIT_STATS_EN undefined: no counter logic; stat_in_cnt and stat_sub_cnt tied to 0.

Verification
REQ-031 len=255, addr=0x8000_0000, MAX_SUB_BEATS=16 -> 16 mst ARs len=15, addr 0x8000_0000 step 0x400; 256 slv R beats, slv_r_last only on beat 256.
REQ-032 len=3 -> single mst AR len=3, same addr; slv_r_last on beat 4.
REQ-033 len=16 -> mst ARs len=15 @A, len=0 @A+0x400; slv_r_last only on beat 17.
REQ-034 mst_r_valid held 0, len=255 -> exactly 8 mst ARs issued then mst_ar_valid=0; releasing R resumes issue, all 16 complete.
REQ-035 rst_n pulsed after 3 of 16 sub-ARs -> no further mst AR, slv_ar_ready=1 next cycle after release, FIFO empty.
REQ-036 With AR_SPLIT_STATS_EN, two len=255 bursts -> stat_in_cnt=2, stat_sub_cnt=32; without macro -> both 0.
